// File: rtl/operand_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry_fsm
// Purpose  : Assembles decimal key presses into a 9-bit two's-complement
//            operand and commits it with a one-cycle enter pulse.
//            Optional sign support is enabled by OPERAND_ENTRY_NEG_EN.
// Revision : 1.0  initial release
// ============================================================================
module operand_entry_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [8:0] op1,
   output logic       enter,
   output logic       neg,
   output logic [1:0] digit_cnt,
   output logic       err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ENTRY  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam logic [3:0] K_NEG  = 4'd10;
   localparam logic [3:0] K_BKSP = 4'd11;
   localparam logic [3:0] K_CLR  = 4'd12;
   localparam logic [3:0] K_ENT  = 4'd13;

   logic [1:0] state, state_n;
   logic [3:0] d2, d1, d0, d2_n, d1_n, d0_n;
   logic [1:0] cnt, cnt_n;
   logic       neg_q, neg_n;
   logic       err_q, err_n;

   logic [7:0]  mag;
   logic [11:0] new_val;
   logic [8:0]  mag9;

   // Accepted values never exceed 255, so 8-bit arithmetic cannot wrap.
   assign mag     = 8'(d2) * 8'd100 + 8'(d1) * 8'd10 + 8'(d0);
   assign new_val = {4'b0, mag} * 12'd10 + {8'b0, key_code};
   assign mag9    = {1'b0, mag};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         d2    <= 4'd0;
         d1    <= 4'd0;
         d0    <= 4'd0;
         cnt   <= 2'd0;
         neg_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         d2    <= d2_n;
         d1    <= d1_n;
         d0    <= d0_n;
         cnt   <= cnt_n;
         neg_q <= neg_n;
         err_q <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      d2_n    = d2;
      d1_n    = d1;
      d0_n    = d0;
      cnt_n   = cnt;
      neg_n   = neg_q;
      err_n   = err_q;
      if (state == S_COMMIT) begin
         // Keys arriving during the commit cycle are dropped, not queued.
         state_n = S_IDLE;
         d2_n    = 4'd0;
         d1_n    = 4'd0;
         d0_n    = 4'd0;
         cnt_n   = 2'd0;
         neg_n   = 1'b0;
         err_n   = 1'b0;
      end else if (key_valid) begin
         if (key_code <= 4'd9) begin
            if (!(state == S_IDLE && key_code == 4'd0)) begin
               if (cnt != 2'd3 && new_val <= 12'd255) begin
                  d2_n    = d1;
                  d1_n    = d0;
                  d0_n    = key_code;
                  cnt_n   = cnt + 2'd1;
                  state_n = S_ENTRY;
               end else begin
                  err_n = 1'b1;
               end
            end
         end else begin
            case (key_code)
`ifdef OPERAND_ENTRY_NEG_EN
               K_NEG: neg_n = ~neg_q;
`endif
               K_BKSP: begin
                  if (state == S_ENTRY) begin
                     d0_n  = d1;
                     d1_n  = d2;
                     d2_n  = 4'd0;
                     cnt_n = cnt - 2'd1;
                     if (cnt == 2'd1) state_n = S_IDLE;
                  end
               end
               K_CLR: begin
                  state_n = S_IDLE;
                  d2_n    = 4'd0;
                  d1_n    = 4'd0;
                  d0_n    = 4'd0;
                  cnt_n   = 2'd0;
                  neg_n   = 1'b0;
                  err_n   = 1'b0;
               end
               K_ENT:   state_n = S_COMMIT;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      enter     = (state == S_COMMIT);
      neg       = neg_q;
      digit_cnt = cnt;
      err       = err_q;
      op1       = neg_q ? (~mag9 + 9'd1) : mag9;
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_fsm.sv
`default_nettype none
// Directed self-checking bench for operand_entry_fsm; expectations follow
// OPERAND_ENTRY_NEG_EN when the bench is built with it.
module tb_operand_entry_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [8:0] op1;
   logic       enter;
   logic       neg;
   logic [1:0] digit_cnt;
   logic       err;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   operand_entry_fsm dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .op1       (op1),
      .enter     (enter),
      .neg       (neg),
      .digit_cnt (digit_cnt),
      .err       (err)
   );

   // Drives one key for one cycle; returns at the negedge after it was sampled.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic [1:0] act, input logic [1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk9("reset_op1", op1, 9'h000);
      chk1("reset_enter", {1'b0, enter}, 2'd0);
      chk1("reset_err", {1'b0, err}, 2'd0);
      chk1("reset_cnt", digit_cnt, 2'd0);
      chk1("reset_neg", {1'b0, neg}, 2'd0);
   endtask

   task automatic test_commit();
      press(4'd1); press(4'd2); press(4'd3);
      chk9("commit_pre_op1", op1, 9'h07B);
      chk1("commit_pre_cnt", digit_cnt, 2'd3);
      chk1("commit_pre_enter", {1'b0, enter}, 2'd0);
      press(4'd13);
      chk1("commit_enter", {1'b0, enter}, 2'd1);
      chk9("commit_op1", op1, 9'h07B);
      @(negedge clk);
      chk1("commit_enter_drop", {1'b0, enter}, 2'd0);
      chk9("commit_after_op1", op1, 9'h000);
      chk1("commit_after_cnt", digit_cnt, 2'd0);
   endtask

   task automatic test_overflow();
      press(4'd2); press(4'd5); press(4'd6);
      chk1("ovf_err", {1'b0, err}, 2'd1);
      chk9("ovf_op1", op1, 9'h019);
      chk1("ovf_cnt", digit_cnt, 2'd2);
      press(4'd13);
      chk1("ovf_enter", {1'b0, enter}, 2'd1);
      chk9("ovf_commit_op1", op1, 9'h019);
      @(negedge clk);
      chk1("ovf_err_cleared", {1'b0, err}, 2'd0);
      // Fourth digit is refused even though the value would fit in range.
      press(4'd1); press(4'd0); press(4'd0); press(4'd5);
      chk9("cnt3_op1", op1, 9'h064);
      chk1("cnt3_err", {1'b0, err}, 2'd1);
      press(4'd12);
      chk1("clr_err", {1'b0, err}, 2'd0);
      chk9("clr_op1", op1, 9'h000);
   endtask

   task automatic test_neg();
      press(4'd10); press(4'd5);
`ifdef OPERAND_ENTRY_NEG_EN
      chk9("neg_op1", op1, 9'h1FB);
      chk1("neg_flag", {1'b0, neg}, 2'd1);
`else
      chk9("neg_op1", op1, 9'h005);
      chk1("neg_flag", {1'b0, neg}, 2'd0);
`endif
      press(4'd13);
      chk1("neg_enter", {1'b0, enter}, 2'd1);
`ifdef OPERAND_ENTRY_NEG_EN
      chk9("neg_commit_op1", op1, 9'h1FB);
`else
      chk9("neg_commit_op1", op1, 9'h005);
`endif
      @(negedge clk);
      chk1("neg_cleared", {1'b0, neg}, 2'd0);
      press(4'd2); press(4'd5); press(4'd5); press(4'd10);
`ifdef OPERAND_ENTRY_NEG_EN
      chk9("neg_min_op1", op1, 9'h101);
`else
      chk9("neg_min_op1", op1, 9'h0FF);
`endif
      press(4'd12);
   endtask

   task automatic test_bksp();
      press(4'd1); press(4'd2); press(4'd11); press(4'd7);
      chk9("bksp_op1", op1, 9'h011);
      chk1("bksp_cnt", digit_cnt, 2'd2);
      press(4'd11); press(4'd11);
      chk1("bksp_empty_cnt", digit_cnt, 2'd0);
      press(4'd11);
      chk9("bksp_idle_op1", op1, 9'h000);
      press(4'd3); press(4'd12);
      chk9("clr_op1b", op1, 9'h000);
      chk1("clr_cnt", digit_cnt, 2'd0);
   endtask

   task automatic test_leading_zero_and_ignored();
      press(4'd0); press(4'd0);
      chk1("lz_cnt", digit_cnt, 2'd0);
      chk1("lz_err", {1'b0, err}, 2'd0);
      press(4'd7); press(4'd14); press(4'd15);
      chk9("ign_op1", op1, 9'h007);
      chk1("ign_cnt", digit_cnt, 2'd1);
      press(4'd0);
      chk9("trail_zero_op1", op1, 9'h046);
      press(4'd12);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      key_valid = 1'b1; key_code = 4'd9;
      @(negedge clk);
      key_code = 4'd8;
      @(negedge clk);
      key_valid = 1'b0;
      chk9("b2b_op1", op1, 9'h062);
      chk1("b2b_cnt", digit_cnt, 2'd2);
      press(4'd12);
   endtask

   task automatic test_reset_mid();
      press(4'd4); press(4'd2);
      @(negedge clk);
      key_valid = 1'b1; key_code = 4'd13; rst = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; rst = 1'b0;
      chk1("rstent_enter", {1'b0, enter}, 2'd0);
      chk9("rstent_op1", op1, 9'h000);
      @(negedge clk);
      chk1("rstent_enter_late", {1'b0, enter}, 2'd0);
      // Digit presented during the commit cycle must be dropped.
      press(4'd3); press(4'd13);
      chk1("drop_enter", {1'b0, enter}, 2'd1);
      key_valid = 1'b1; key_code = 4'd9;
      @(negedge clk);
      key_valid = 1'b0;
      chk9("drop_op1", op1, 9'h000);
      chk1("drop_cnt", digit_cnt, 2'd0);
      // Reset during commit cancels the pulse at that edge.
      press(4'd6); press(4'd13);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk1("rstcommit_enter", {1'b0, enter}, 2'd0);
      chk9("rstcommit_op1", op1, 9'h000);
   endtask

   initial begin
      test_reset();
      test_commit();
      test_overflow();
      test_neg();
      test_bksp();
      test_leading_zero_and_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
